// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern transmitter and the sequence detectors it drives.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } seq_tx_state_t;

  localparam int unsigned DEF_MAXLEN = 8;
  localparam int unsigned DEF_GAPW   = 4;

  // Reference patterns, right-aligned, with their lengths.
  localparam logic [2:0]  PAT_101     = 3'b101;
  localparam int unsigned PAT_101_LEN = 3;

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: emits a loaded pattern MSB-first, one bit per clock,
// with optional zero gaps and repetitions.
module seq_pattern_tx
  import seq_det_pkg::*;
#(
  parameter int unsigned MAXLEN = DEF_MAXLEN,
  parameter int unsigned GAPW   = DEF_GAPW,
  parameter int unsigned LENW   = $clog2(MAXLEN) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [MAXLEN-1:0] load_pattern,
  input  logic [LENW-1:0]   load_len,
  input  logic [GAPW-1:0]   load_gap,
  input  logic [7:0]        load_repeat,
  output logic              out,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  seq_tx_state_t     r_state;
  logic [MAXLEN-1:0] r_pat;
  logic [LENW-1:0]   r_len;
  logic [GAPW-1:0]   r_gap;
  logic [LENW-1:0]   r_idx;
  logic [GAPW-1:0]   r_gcnt;
  logic [7:0]        r_rep;
  logic [LENW-1:0]   w_len;

  assign w_len = (load_len > LENW'(MAXLEN)) ? LENW'(MAXLEN) : load_len;

  function automatic logic bit_at(input logic [MAXLEN-1:0] pat, input logic [LENW-1:0] idx);
    logic [MAXLEN-1:0] s;
    s = pat >> idx;
    return s[0];
  endfunction

  // Outputs describe the bit on the line this cycle; done is precomputed for the bit being loaded.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_pat      <= '0;
      r_len      <= '0;
      r_gap      <= '0;
      r_idx      <= '0;
      r_gcnt     <= '0;
      r_rep      <= '0;
      out        <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (load_valid) begin
            r_pat <= load_pattern;
            r_len <= w_len;
            r_gap <= load_gap;
            r_rep <= load_repeat;
            if (w_len != '0) begin
              r_state    <= SHIFT;
              r_idx      <= w_len - LENW'(1);
              out        <= bit_at(load_pattern, w_len - LENW'(1));
              out_valid  <= 1'b1;
              busy       <= 1'b1;
              load_ready <= 1'b0;
              done       <= (w_len == LENW'(1)) && (load_gap == '0) && (load_repeat == '0);
            end else begin
              done <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (r_idx != '0) begin
            r_idx <= r_idx - LENW'(1);
            out   <= bit_at(r_pat, r_idx - LENW'(1));
            done  <= (r_idx == LENW'(1)) && (r_gap == '0) && (r_rep == '0);
          end else if (r_gap != '0) begin
            r_state <= GAP;
            r_gcnt  <= r_gap - GAPW'(1);
            out     <= 1'b0;
            done    <= (r_gap == GAPW'(1)) && (r_rep == '0);
          end else if (r_rep != '0) begin
            r_rep <= r_rep - 8'd1;
            r_idx <= r_len - LENW'(1);
            out   <= bit_at(r_pat, r_len - LENW'(1));
            done  <= (r_len == LENW'(1)) && (r_rep == 8'd1);
          end else begin
            r_state    <= IDLE;
            out        <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
          end
        end
        GAP: begin
          if (r_gcnt != '0) begin
            r_gcnt <= r_gcnt - GAPW'(1);
            done   <= (r_gcnt == GAPW'(1)) && (r_rep == '0);
          end else if (r_rep != '0) begin
            // Gap is non-zero here, so the first bit of a new copy is never the final one.
            r_state <= SHIFT;
            r_rep   <= r_rep - 8'd1;
            r_idx   <= r_len - LENW'(1);
            out     <= bit_at(r_pat, r_len - LENW'(1));
            done    <= 1'b0;
          end else begin
            r_state    <= IDLE;
            out        <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          out        <= 1'b0;
          out_valid  <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: directed cases plus random loads against a queue-based model.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rstn;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_pattern;
  logic [3:0] load_len;
  logic [3:0] load_gap;
  logic [7:0] load_repeat;
  logic       out;
  logic       out_valid;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  bit q[$];
  bit m_busy = 1'b0;
  int n_done = 0;

  always #5 clk = ~clk;

  seq_pattern_tx #(.MAXLEN(8), .GAPW(4), .LENW(4)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_pattern (load_pattern),
    .load_len     (load_len),
    .load_gap     (load_gap),
    .load_repeat  (load_repeat),
    .out          (out),
    .out_valid    (out_valid),
    .busy         (busy),
    .done         (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model by one stream bit, compare after the edge.
  task automatic cyc(input logic v, input logic [7:0] p, input logic [3:0] l,
                     input logic [3:0] g, input logic [7:0] r, input logic rs);
    int  clen;
    bit  popped;
    bit  b;
    bit  e_done;
    @(negedge clk);
    rstn = rs; load_valid = v; load_pattern = p; load_len = l; load_gap = g; load_repeat = r;
    popped = 1'b0; b = 1'b0; e_done = 1'b0;
    if (!rs) begin
      q.delete();
    end else if (!m_busy && v) begin
      clen = (int'(l) > 8) ? 8 : int'(l);
      if (clen == 0) e_done = 1'b1;
      else
        for (int c = 0; c <= int'(r); c++) begin
          for (int i = clen - 1; i >= 0; i--) q.push_back(p[i]);
          for (int k = 0; k < int'(g); k++) q.push_back(1'b0);
        end
    end
    if (rs && q.size() > 0) begin
      b = q.pop_front();
      popped = 1'b1;
      e_done = (q.size() == 0);
    end
    m_busy = popped;
    @(posedge clk);
    #1;
    if (done === 1'b1) n_done++;
    check_eq("out",        32'(out),        32'(b));
    check_eq("out_valid",  32'(out_valid),  32'(popped));
    check_eq("busy",       32'(busy),       32'(popped));
    check_eq("load_ready", 32'(load_ready), 32'(!popped));
    check_eq("done",       32'(done),       32'(e_done));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 4'd0, 4'd0, 8'd0, 1'b1);
  endtask

  initial begin
    rstn = 1'b0; load_valid = 1'b0; load_pattern = '0; load_len = '0; load_gap = '0; load_repeat = '0;
    cyc(1'b0, 8'h00, 4'd0, 4'd0, 8'd0, 1'b0);
    cyc(1'b0, 8'h00, 4'd0, 4'd0, 8'd0, 1'b0);
    idle(2);

    // 101 once, then 101 with gap 2 repeated three times: exactly one done per stream
    n_done = 0;
    cyc(1'b1, 8'h05, 4'd3, 4'd0, 8'd0, 1'b1);
    idle(5);
    cyc(1'b1, 8'h05, 4'd3, 4'd2, 8'd2, 1'b1);
    idle(17);
    check_eq("done_count_101", 32'(n_done), 32'd2);

    // zero length: done only, no stream
    cyc(1'b1, 8'hFF, 4'd0, 4'd3, 8'd5, 1'b1);
    idle(3);

    // length clamp: 10 -> 8
    cyc(1'b1, 8'hA5, 4'd10, 4'd0, 8'd0, 1'b1);
    idle(10);

    // reset in the middle of an all-ones stream
    cyc(1'b1, 8'hFF, 4'd8, 4'd0, 8'd0, 1'b1);
    idle(2);
    n_done = 0;
    cyc(1'b0, 8'h00, 4'd0, 4'd0, 8'd0, 1'b0);
    idle(10);
    check_eq("done_after_reset", 32'(n_done), 32'd0);

    // new load held throughout a busy stream is taken only once idle
    cyc(1'b1, 8'h05, 4'd3, 4'd1, 8'd1, 1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b1, 8'h3C, 4'd6, 4'd0, 8'd0, 1'b1);
    idle(10);

    // single-bit patterns around gap/repeat corners
    cyc(1'b1, 8'h01, 4'd1, 4'd0, 8'd2, 1'b1);
    idle(5);
    cyc(1'b1, 8'h01, 4'd1, 4'd1, 8'd1, 1'b1);
    idle(6);

    // random traffic with rare resets
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 2) == 0),
          8'($urandom), 4'($urandom_range(0, 11)), 4'($urandom_range(0, 5)),
          8'($urandom_range(0, 3)), ($urandom_range(0, 299) != 0));
    end
    idle(120);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter: accepts a bit pattern, length, gap and repeat count over a valid/ready load port. It emits the pattern MSB-first on a one-bit line, one bit per clock, with optional idle-zero gaps and repetitions. It is the stimulus/transmit end for the team's serial sequence detectors (for example 101 non-overlapping Moore). It sits in front of a detector's `in` pin in self-test and loopback configurations.

## Interface
- `MAXLEN`, default 8: maximum pattern length in bits; must be ≥ 2.
- `GAPW`, default 4: width of the gap-length field.
- `LENW`, default $clog2(MAXLEN)+1: width of the length field.
- `clk` input 1: clock, rising edge.
- `rstn` input 1: reset, synchronous, active-low.
- `load_valid` input 1: load request.
- `load_ready` output 1: block can accept a load.
- `load_pattern` input MAXLEN: pattern bits, right-aligned; bit `len-1` is sent first.
- `load_len` input LENW: pattern length. 0 means no bits; values above MAXLEN are clamped to MAXLEN.
- `load_gap` input GAPW: number of zero bits sent after each pattern copy.
- `load_repeat` input 8: extra repetitions; total copies = `load_repeat` + 1.
- `out` output 1: serial data bit.
- `out_valid` output 1: `out` is a driven stream bit (pattern or gap).
- `busy` output 1: a frame sequence is in progress.
- `done` output 1: single-cycle pulse marking the final stream bit.

## Operation
- FSM states: IDLE, SHIFT, GAP.
- **IDLE**
  - `load_ready`=1. All other outputs are 0.
  - On `load_valid`&`load_ready`, latch pattern, clamped length, gap and repeat.
  - If the clamped length > 0: go to SHIFT with bit index = len-1.
  - If the clamped length = 0: stay in IDLE and pulse `done` for one cycle; no `out_valid`.
- **SHIFT**
  - Each cycle: `out`=pattern[index], `out_valid`=1, index decrements.
  - After index 0: if gap > 0, go to GAP with gap counter = gap-1.
  - Otherwise, if repeats remain, decrement the repeat counter and return to SHIFT at index len-1.
  - Otherwise go to IDLE.
- **GAP**
  - Each cycle: `out`=0, `out_valid`=1.
  - After the last gap bit: if repeats remain, decrement the repeat counter and go to SHIFT.
  - Otherwise go to IDLE.
- A stream has no idle cycles between copies. Total `out_valid` cycles = (repeat+1)×(len+gap).
- `busy`=1 in SHIFT and GAP.
- `done`=1 in the cycle carrying the last stream bit (last pattern bit or last gap bit of the final copy).
- `load_valid` is ignored while not IDLE; latched fields are never modified mid-stream.
- All outputs are registered.

## Timing
- Reset (`rstn`=0 at a rising edge): state IDLE; `out`=0, `out_valid`=0, `busy`=0, `done`=0, `load_ready`=1. Counters are cleared.
- Load latency: handshake in cycle T → first bit on `out` in T+1.
- Last stream bit in cycle L → IDLE and `load_ready`=1 in L+1. Next handshake is possible at L+1, giving its first bit at L+2. Minimum inter-stream spacing is one idle cycle.
- Zero-length load at T → `done`=1 at T+1 only; `load_ready` stays 1.
- Reset mid-stream: takes effect at the next edge. The in-flight stream is discarded, no `done` is pulsed, and reset values apply.
- Counters:
  - Index counter is LENW bits.
  - Gap counter is GAPW bits.
  - Repeat counter is 8 bits.
  - No counter wraps; every counter is compared to zero before decrementing.

## Structure
- Shared package `seq_det_pkg`:
  - State typedef `seq_tx_state_t` {IDLE, SHIFT, GAP}.
  - Default `MAXLEN`/`GAPW` constants.
  - Pattern constants, e.g. `PAT_101` = 3'b101 with length 3, shared with the detectors.
- No sub-module; a single flat module with one FSM and three down-counters.

## Test plan
- Load pattern 3'b101, len 3, gap 0, repeat 0 at T → `out` = 1,0,1 at T+1..T+3 with `out_valid`=1; `done` at T+3; `load_ready`=1 at T+4.
- Pattern 3'b101, len 3, gap 2, repeat 2 → stream 1,0,1,0,0 ×3 (15 valid cycles); `done` at T+15. Looped into the 101 non-overlapping Moore detector, the detector output rises exactly 3 times.
- len 0, repeat 5 → `out_valid` never asserted; `done` at T+1 only.
- `MAXLEN`=8, len 10, pattern 8'hA5 → 8 bits sent: 1,0,1,0,0,1,0,1; `done` at T+8.
- `rstn`=0 during SHIFT at bit 2 of 8'hFF → next cycle `out`=0, `out_valid`=0, `busy`=0, `load_ready`=1; no `done`.
- `load_valid`=1 with a new pattern held throughout a busy stream → current stream completes unchanged; new pattern accepted only in the first IDLE cycle after `done`.
